// File: rtl/encounter_pkg.sv
//------------------------------------------------------------------------------
// encounter_pkg : states, status code and sprite frame codes for the flower
//                 encounter sequencer.
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package encounter_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    INTRO1     = 3'd1,
    INTRO2     = 3'd2,
    WAVE_START = 3'd3,
    WAVE_RUN   = 3'd4,
    GAP        = 3'd5,
    DONE       = 3'd6
  } enc_state_t;

  localparam logic [3:0] BATTLE_STATUS = 4'd5;

  localparam logic [1:0] FLOWER_NONE = 2'd0;
  localparam logic [1:0] FLOWER_1    = 2'd1;
  localparam logic [1:0] FLOWER_2    = 2'd2;
  localparam logic [1:0] FLOWER_3    = 2'd3;

  localparam int TICK_W = 12;

endpackage

`default_nettype wire

// File: rtl/tick_counter.sv
//------------------------------------------------------------------------------
// tick_counter : frame up-counter with synchronous clear, enable and a
//                terminal-count compare against a caller-selected value.
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tick_counter #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_terminal,
  output logic             o_at_terminal
);

  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + c_one;
    end
  end

  assign o_at_terminal = (r_count == i_terminal);

endmodule

`default_nettype wire

// File: rtl/encounter_sequencer.sv
//------------------------------------------------------------------------------
// encounter_sequencer : Moore sequencer for the flower encounter -- intro
//                       frames, timed bullet waves with gaps, then done.
// Revision            : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module encounter_sequencer
  import encounter_pkg::*;
#(
  parameter int INTRO_TICKS = 120,
  parameter int WAVE_TICKS  = 3600,
  parameter int GAP_TICKS   = 60,
  parameter int NUM_WAVES   = 4
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic [3:0] status,
  input  logic       pause,
  input  logic       wave_done,
  output logic [1:0] flower_num,
  output logic       start_bullet,
  output logic       bullet_active,
  output logic [2:0] wave_idx,
  output logic       time_up
);

  generate
    if (INTRO_TICKS < 1 || INTRO_TICKS > 4095 || WAVE_TICKS < 1 || WAVE_TICKS > 4095 ||
        GAP_TICKS < 1 || GAP_TICKS > 4095 || NUM_WAVES < 1 || NUM_WAVES > 8) begin : g_param_check
      $error("encounter_sequencer: tick or wave parameter out of range");
    end
  endgenerate

  localparam logic [TICK_W-1:0] c_intro_term = TICK_W'(INTRO_TICKS - 1);
  localparam logic [TICK_W-1:0] c_wave_term  = TICK_W'(WAVE_TICKS - 1);
  localparam logic [TICK_W-1:0] c_gap_term   = TICK_W'(GAP_TICKS - 1);
  localparam logic [2:0]        c_last_wave  = 3'(NUM_WAVES - 1);

  enc_state_t        r_state, w_next_state;
  logic [2:0]        r_wave_idx, w_next_wave_idx;
  logic [1:0]        r_flower_num, w_next_flower_num;
  logic              r_start_bullet, r_bullet_active, r_time_up;
  logic [TICK_W-1:0] w_terminal;
  logic              w_count_en, w_at_terminal, w_tick, w_clear, w_battle;

  // Counting states hold their count while paused; a paused terminal count
  // does not advance the state.
  always_comb begin
    w_terminal = c_intro_term;
    w_count_en = 1'b0;
    case (r_state)
      INTRO1, INTRO2: w_count_en = !pause;
      WAVE_RUN: begin
        w_terminal = c_wave_term;
        w_count_en = !pause;
      end
      GAP: begin
        w_terminal = c_gap_term;
        w_count_en = !pause;
      end
      default: ;
    endcase
  end

  assign w_tick   = w_at_terminal && w_count_en;
  assign w_battle = (status == BATTLE_STATUS);
  assign w_clear  = (w_next_state != r_state);

  tick_counter #(
    .WIDTH (TICK_W)
  ) u_tick_counter (
    .clk           (frame_clk),
    .rst_n         (Reset_n),
    .i_clear       (w_clear),
    .i_enable      (w_count_en),
    .i_terminal    (w_terminal),
    .o_at_terminal (w_at_terminal)
  );

  always_comb begin
    w_next_state    = r_state;
    w_next_wave_idx = r_wave_idx;
    case (r_state)
      IDLE:       if (w_battle) w_next_state = INTRO1;
      INTRO1:     if (w_tick) w_next_state = INTRO2;
      INTRO2:     if (w_tick) w_next_state = WAVE_START;
      WAVE_START: w_next_state = WAVE_RUN;
      WAVE_RUN: begin
        if (wave_done || w_tick) begin
          w_next_state = (r_wave_idx == c_last_wave) ? DONE : GAP;
        end
      end
      GAP: begin
        if (w_tick) begin
          w_next_state    = WAVE_START;
          w_next_wave_idx = r_wave_idx + 3'd1;
        end
      end
      DONE:       ;
      default:    w_next_state = IDLE;
    endcase

    if (r_state != IDLE && !w_battle) begin
      w_next_state = IDLE;
    end
    if (w_next_state == IDLE) begin
      w_next_wave_idx = '0;
    end

    case (w_next_state)
      IDLE:    w_next_flower_num = FLOWER_NONE;
      INTRO1:  w_next_flower_num = FLOWER_1;
      INTRO2:  w_next_flower_num = FLOWER_2;
      default: w_next_flower_num = FLOWER_3;
    endcase
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state         <= IDLE;
      r_wave_idx      <= '0;
      r_flower_num    <= FLOWER_NONE;
      r_start_bullet  <= 1'b0;
      r_bullet_active <= 1'b0;
      r_time_up       <= 1'b0;
    end else begin
      r_state         <= w_next_state;
      r_wave_idx      <= w_next_wave_idx;
      r_flower_num    <= w_next_flower_num;
      r_start_bullet  <= (w_next_state == WAVE_START);
      r_bullet_active <= (w_next_state == WAVE_RUN);
      r_time_up       <= (w_next_state == DONE);
    end
  end

  assign flower_num    = r_flower_num;
  assign start_bullet  = r_start_bullet;
  assign bullet_active = r_bullet_active;
  assign wave_idx      = r_wave_idx;
  assign time_up       = r_time_up;

endmodule

`default_nettype wire

// File: tb/tb_encounter_sequencer.sv
//------------------------------------------------------------------------------
// tb_encounter_sequencer : scoreboard bench for encounter_sequencer against a
//                          phase/countdown reference model.
// Revision               : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_encounter_sequencer;

  localparam int INTRO  = 3;
  localparam int WAVE   = 5;
  localparam int GAPT   = 2;
  localparam int NWAVES = 2;

  localparam int P_IDLE   = 0;
  localparam int P_INTRO1 = 1;
  localparam int P_INTRO2 = 2;
  localparam int P_LAUNCH = 3;
  localparam int P_RUN    = 4;
  localparam int P_GAP    = 5;
  localparam int P_DONE   = 6;

  logic       frame_clk = 1'b0;
  logic       Reset_n;
  logic [3:0] status;
  logic       pause;
  logic       wave_done;
  logic [1:0] flower_num;
  logic       start_bullet;
  logic       bullet_active;
  logic [2:0] wave_idx;
  logic       time_up;

  typedef struct packed {
    logic [1:0] fl;
    logic       sb;
    logic       ba;
    logic [2:0] wi;
    logic       tu;
  } snap_t;

  snap_t exp_q[$];
  int    pulse_q[$];
  snap_t mon_exp, mon_act;
  int    mon_pulse;

  int checks = 0;
  int errors = 0;

  // Reference model: current phase, frames still to count in it, wave number.
  int m_phase = P_IDLE;
  int m_left  = 0;
  int m_wave  = 0;

  int         abort_left = 0;
  logic [3:0] rs;
  logic       rp, rwd;

  always #5 frame_clk = ~frame_clk;

  encounter_sequencer #(
    .INTRO_TICKS (INTRO),
    .WAVE_TICKS  (WAVE),
    .GAP_TICKS   (GAPT),
    .NUM_WAVES   (NWAVES)
  ) dut (
    .frame_clk     (frame_clk),
    .Reset_n       (Reset_n),
    .status        (status),
    .pause         (pause),
    .wave_done     (wave_done),
    .flower_num    (flower_num),
    .start_bullet  (start_bullet),
    .bullet_active (bullet_active),
    .wave_idx      (wave_idx),
    .time_up       (time_up)
  );

  task automatic model_step(input logic rn, input logic [3:0] st, input logic p, input logic wd);
    if (!rn || (m_phase != P_IDLE && st != 4'd5)) begin
      m_phase = P_IDLE;
      m_wave  = 0;
      m_left  = 0;
      return;
    end
    case (m_phase)
      P_IDLE: if (st == 4'd5) begin
        m_phase = P_INTRO1;
        m_left  = INTRO;
      end
      P_INTRO1, P_INTRO2: begin
        if (!p) m_left--;
        if (m_left == 0) begin
          m_phase = m_phase + 1;
          m_left  = INTRO;
        end
      end
      P_LAUNCH: begin
        m_phase = P_RUN;
        m_left  = WAVE;
      end
      P_RUN: begin
        if (!p) m_left--;
        if (wd || m_left == 0) begin
          m_phase = (m_wave == NWAVES - 1) ? P_DONE : P_GAP;
          m_left  = GAPT;
        end
      end
      P_GAP: begin
        if (!p) m_left--;
        if (m_left == 0) begin
          m_phase = P_LAUNCH;
          m_wave++;
        end
      end
      default: ;
    endcase
  endtask

  function automatic snap_t model_out();
    snap_t s;
    s = '0;
    case (m_phase)
      P_IDLE:   s.fl = 2'd0;
      P_INTRO1: s.fl = 2'd1;
      P_INTRO2: s.fl = 2'd2;
      default:  s.fl = 2'd3;
    endcase
    s.sb = (m_phase == P_LAUNCH);
    s.ba = (m_phase == P_RUN);
    s.tu = (m_phase == P_DONE);
    s.wi = 3'(m_wave);
    return s;
  endfunction

  // Drive one frame of stimulus and queue what the next edge must produce.
  task automatic cycle(input logic rn, input logic [3:0] st, input logic p, input logic wd);
    snap_t e;
    @(negedge frame_clk);
    Reset_n   = rn;
    status    = st;
    pause     = p;
    wave_done = wd;
    model_step(rn, st, p, wd);
    e = model_out();
    exp_q.push_back(e);
    if (e.sb) pulse_q.push_back(m_wave);
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if ({flower_num, start_bullet, bullet_active, wave_idx, time_up} !== 8'd0) begin
      errors++;
      $display("FAIL %s got fl=%0d sb=%b ba=%b wi=%0d tu=%b want all zero",
               tag, flower_num, start_bullet, bullet_active, wave_idx, time_up);
    end
  endtask

  always @(posedge frame_clk) begin
    #1;
    mon_act = {flower_num, start_bullet, bullet_active, wave_idx, time_up};
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      checks++;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("FAIL outputs t=%0t got fl=%0d sb=%b ba=%b wi=%0d tu=%b want fl=%0d sb=%b ba=%b wi=%0d tu=%b",
                 $time, mon_act.fl, mon_act.sb, mon_act.ba, mon_act.wi, mon_act.tu,
                 mon_exp.fl, mon_exp.sb, mon_exp.ba, mon_exp.wi, mon_exp.tu);
      end
    end
    if (start_bullet === 1'b1) begin
      checks++;
      if (pulse_q.size() == 0) begin
        errors++;
        $display("FAIL start_pulse t=%0t got unexpected pulse wi=%0d want none", $time, wave_idx);
      end else begin
        mon_pulse = pulse_q.pop_front();
        if (int'(wave_idx) != mon_pulse) begin
          errors++;
          $display("FAIL start_pulse_idx t=%0t got wi=%0d want %0d", $time, wave_idx, mon_pulse);
        end
      end
    end
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog got timeout want completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n   = 1'b0;
    status    = 4'd0;
    pause     = 1'b0;
    wave_done = 1'b0;
    #1;
    check_zero("reset_initial");
    repeat (2) cycle(1'b0, 4'd0, 1'b0, 1'b0);

    // Full encounter, no disturbances.
    for (int i = 0; i < 25; i++) cycle(1'b1, 4'd5, 1'b0, 1'b0);
    repeat (2) cycle(1'b1, 4'd0, 1'b0, 1'b0);

    // Early wave end, then a wave_done pulse while in the gap.
    for (int i = 0; i < 25; i++) cycle(1'b1, 4'd5, 1'b0, (i == 10) || (i == 12));
    repeat (2) cycle(1'b1, 4'd0, 1'b0, 1'b0);

    // Pause in INTRO1 and during WAVE_START.
    for (int i = 0; i < 25; i++) cycle(1'b1, 4'd5, (i >= 1 && i <= 4) || (i == 11), 1'b0);
    repeat (2) cycle(1'b1, 4'd0, 1'b0, 1'b0);

    // Abort mid-wave with wave_done, then restart.
    for (int i = 0; i < 9; i++) cycle(1'b1, 4'd5, 1'b0, 1'b0);
    cycle(1'b1, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) cycle(1'b1, 4'd5, 1'b0, 1'b0);
    repeat (2) cycle(1'b1, 4'd0, 1'b0, 1'b0);

    // Asynchronous reset between edges while in GAP.
    for (int i = 0; i < 13; i++) cycle(1'b1, 4'd5, 1'b0, 1'b0);
    @(posedge frame_clk);
    #3;
    Reset_n = 1'b0;
    #1;
    check_zero("reset_async_gap");
    repeat (2) cycle(1'b0, 4'd5, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 4'd5, 1'b0, 1'b0);

    // Randomized traffic with occasional aborts.
    for (int i = 0; i < 3000; i++) begin
      if (abort_left == 0 && $urandom_range(0, 199) == 0) abort_left = $urandom_range(1, 3);
      if (abort_left > 0) begin
        rs = 4'($urandom_range(0, 15));
        if (rs == 4'd5) rs = 4'd0;
        abort_left--;
      end else begin
        rs = 4'd5;
      end
      rp  = ($urandom_range(0, 3) == 0);
      rwd = ($urandom_range(0, 5) == 0);
      cycle(1'b1, rs, rp, rwd);
    end

    repeat (3) cycle(1'b1, 4'd0, 1'b0, 1'b0);
    @(posedge frame_clk);
    #2;
    checks++;
    if (exp_q.size() != 0 || pulse_q.size() != 0) begin
      errors++;
      $display("FAIL drain got exp=%0d pulses=%0d pending want 0", exp_q.size(), pulse_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
